// File: rtl/fpc_pkg.sv
// fpc_pkg: shared types and helpers for the fetch PC generator.
// Holds the fetch state encoding and the group-offset helper that turns a
// PC into the index of its first active slot within an aligned fetch group.
package fpc_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } fpc_state_e;

  // Index of the slot a PC points at inside its aligned fetch group.
  // Group size is fetch_width*inst_bytes bytes, both powers of two.
  function automatic int unsigned fpc_group_offset(
    input logic [63:0] pc,
    input int unsigned fetch_width,
    input int unsigned inst_bytes
  );
    logic [63:0] group_mask;
    group_mask = 64'(fetch_width * inst_bytes) - 64'd1;
    return 32'((pc & group_mask) / 64'(inst_bytes));
  endfunction

endpackage

// File: rtl/fpc_ras.sv
// fpc_ras: circular return-address stack for the fetch PC generator.
// Push writes above the current top; overflow silently overwrites the oldest
// entry. Popping an empty stack leaves the pointer alone, so the stale top
// stays visible and the occupancy count saturates at zero.
module fpc_ras #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_addr,
  output logic [XLEN-1:0] top
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  stack_r [DEPTH];
  logic [PTR_W-1:0] top_ptr_r;
  logic [PTR_W-1:0] inc_ptr_s;
  logic [PTR_W-1:0] dec_ptr_s;
  logic [CNT_W-1:0] count_r;

  // Wrap-around neighbours of the top pointer (depth need not be a power of two).
  always_comb begin
    inc_ptr_s = '0;
    dec_ptr_s = '0;
    if (top_ptr_r == PTR_W'(DEPTH - 1)) begin
      inc_ptr_s = {PTR_W{1'b0}};
    end else begin
      inc_ptr_s = top_ptr_r + PTR_W'(1);
    end
    if (top_ptr_r == {PTR_W{1'b0}}) begin
      dec_ptr_s = PTR_W'(DEPTH - 1);
    end else begin
      dec_ptr_s = top_ptr_r - PTR_W'(1);
    end
  end

  assign top = stack_r[top_ptr_r];

  // Stack storage, top pointer and occupancy count.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      top_ptr_r <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        stack_r[i] <= {XLEN{1'b0}};
      end
    end else if (push) begin
      stack_r[inc_ptr_s] <= push_addr;
      top_ptr_r          <= inc_ptr_s;
      if (count_r != CNT_W'(DEPTH)) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end else if (pop) begin
      if (count_r != {CNT_W{1'b0}}) begin
        top_ptr_r <= dec_ptr_s;
        count_r   <= count_r - CNT_W'(1);
      end else begin
        top_ptr_r <= top_ptr_r;
        count_r   <= count_r;
      end
    end else begin
      top_ptr_r <= top_ptr_r;
      count_r   <= count_r;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: multi-slot fetch PC generator.
// Issues one aligned fetch group per cycle over valid/ready, picking the next
// PC from backend redirect, the first predicted-taken slot, or the sequential
// group. A redirect squashes the current group and costs one bubble cycle.
// Optional macro FPC_RAS_EN adds an internal return-address stack (fpc_ras);
// without it return targets come from ret_addr and pred_is_call is ignored.
module fetch_pc_gen
  import fpc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              FETCH_WIDTH  = 2,
  parameter int              INST_BYTES   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              RAS_DEPTH    = 8
) (
  input  logic                          CLK,
  input  logic                          reset_n,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic [FETCH_WIDTH-1:0]        pred_valid,
  input  logic [FETCH_WIDTH-1:0]        pred_is_branch,
  input  logic [FETCH_WIDTH-1:0]        pred_taken,
  input  logic [FETCH_WIDTH-1:0]        pred_is_call,
  input  logic [FETCH_WIDTH-1:0]        pred_is_ret,
  input  logic [FETCH_WIDTH*XLEN-1:0]   pred_target,
  input  logic [FETCH_WIDTH*XLEN-1:0]   ret_addr,
  input  logic                          fetch_ready,
  output logic                          fetch_valid,
  output logic [XLEN-1:0]               fetch_pc,
  output logic [FETCH_WIDTH-1:0]        fetch_slot_mask,
  output logic                          fetch_taken,
  output logic [((FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1)-1:0] fetch_taken_slot,
  output logic [XLEN-1:0]               next_pc
);

  localparam int              SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int              GROUP_BYTES = FETCH_WIDTH * INST_BYTES;
  localparam logic [XLEN-1:0] GROUP_MASK  = XLEN'(GROUP_BYTES - 1);
  localparam logic [XLEN-1:0] INST_MASK   = XLEN'(INST_BYTES - 1);

  fpc_state_e        state_r;
  logic [XLEN-1:0]   pc_r;

  int unsigned       first_slot_s;
  logic [XLEN-1:0]   base_s;
  logic [XLEN-1:0]   seq_pc_s;
  logic [XLEN-1:0]   redirect_aligned_s;

  logic [FETCH_WIDTH-1:0] mask_s;
  logic              found_s;
  logic              active_s;
  logic              hit_s;
  logic [SLOT_W-1:0] win_s;
  logic [XLEN-1:0]   win_target_s;
  logic [XLEN-1:0]   win_ret_addr_s;
  logic [XLEN-1:0]   win_link_s;
  logic              win_is_call_s;
  logic              win_is_ret_s;
  logic [XLEN-1:0]   ret_target_s;
  logic [XLEN-1:0]   next_pc_s;

  logic              fetch_valid_s;
  logic              handshake_s;

`ifdef FPC_RAS_EN
  logic [XLEN-1:0]   ras_top_s;
  logic              ras_push_s;
  logic              ras_pop_s;
`endif

  // Group geometry: aligned base, sequential successor, first active slot.
  always_comb begin
    base_s             = pc_r & ~GROUP_MASK;
    seq_pc_s           = base_s + XLEN'(GROUP_BYTES);
    redirect_aligned_s = redirect_pc & ~INST_MASK;
    first_slot_s       = fpc_group_offset(64'(pc_r), unsigned'(FETCH_WIDTH),
                                          unsigned'(INST_BYTES));
  end

  // Priority encoder: lowest active slot that redirects wins and ends the group.
  always_comb begin
    mask_s         = '0;
    found_s        = 1'b0;
    active_s       = 1'b0;
    hit_s          = 1'b0;
    win_s          = '0;
    win_target_s   = '0;
    win_ret_addr_s = '0;
    win_link_s     = '0;
    win_is_call_s  = 1'b0;
    win_is_ret_s   = 1'b0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      active_s  = (unsigned'(i) >= first_slot_s) && !found_s;
      mask_s[i] = active_s;
      hit_s     = active_s && pred_valid[i] &&
                  (pred_is_ret[i] || !pred_is_branch[i] || pred_taken[i]);
      win_s          = hit_s ? SLOT_W'(i) : win_s;
      win_target_s   = hit_s ? pred_target[i*XLEN +: XLEN] : win_target_s;
      win_ret_addr_s = hit_s ? ret_addr[i*XLEN +: XLEN] : win_ret_addr_s;
      win_link_s     = hit_s ? (base_s + XLEN'((i + 1) * INST_BYTES)) : win_link_s;
      win_is_call_s  = hit_s ? pred_is_call[i] : win_is_call_s;
      win_is_ret_s   = hit_s ? pred_is_ret[i] : win_is_ret_s;
      found_s        = found_s | hit_s;
    end
  end

  // Successor PC: return target, predicted target, or next sequential group.
  always_comb begin
`ifdef FPC_RAS_EN
    ret_target_s = ras_top_s;
`else
    ret_target_s = win_ret_addr_s;
`endif
    if (!found_s) begin
      next_pc_s = seq_pc_s;
    end else if (win_is_ret_s) begin
      next_pc_s = ret_target_s;
    end else begin
      next_pc_s = win_target_s;
    end
  end

  // A group is offered only in RUN and is squashed by a same-cycle redirect.
  always_comb begin
    fetch_valid_s = reset_n && (state_r == RUN) && !redirect_valid;
    handshake_s   = fetch_valid_s && fetch_ready;
  end

  assign fetch_valid      = fetch_valid_s;
  assign fetch_pc         = pc_r;
  assign fetch_slot_mask  = fetch_valid_s ? mask_s : {FETCH_WIDTH{1'b0}};
  assign fetch_taken      = fetch_valid_s & found_s;
  assign fetch_taken_slot = fetch_valid_s ? win_s : {SLOT_W{1'b0}};
  assign next_pc          = next_pc_s;

  // Fetch state and PC: reset, then redirect, then normal progression.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_r <= BOOT;
      pc_r    <= RESET_VECTOR & ~INST_MASK;
    end else if (redirect_valid) begin
      state_r <= BUBBLE;
      pc_r    <= redirect_aligned_s;
    end else begin
      case (state_r)
        BOOT: begin
          state_r <= RUN;
        end
        BUBBLE: begin
          state_r <= RUN;
        end
        RUN: begin
          if (handshake_s) begin
            pc_r <= next_pc_s;
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          state_r <= BOOT;
        end
      endcase
    end
  end

`ifdef FPC_RAS_EN
  // A winning return pops; a winning call pushes its fall-through address.
  assign ras_pop_s  = handshake_s && found_s && win_is_ret_s;
  assign ras_push_s = handshake_s && found_s && win_is_call_s && !win_is_ret_s;

  fpc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .push      (ras_push_s),
    .pop       (ras_pop_s),
    .push_addr (win_link_s),
    .top       (ras_top_s)
  );

  logic unused_s;
  assign unused_s = ^win_ret_addr_s;
`else
  logic unused_s;
  assign unused_s = ^{win_is_call_s, win_link_s};
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: self-checking bench for fetch_pc_gen (FETCH_WIDTH=2,
// INST_BYTES=4, RESET_VECTOR=0x1000). Directed table, hand sequences for
// multi-cycle cases, then randomized traffic against a behavioural model.
module tb_fetch_pc_gen;

  logic        CLK;
  logic        reset_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  pred_valid, pred_is_branch, pred_taken, pred_is_call, pred_is_ret;
  logic [63:0] pred_target;
  logic [63:0] ret_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [1:0]  fetch_slot_mask;
  logic        fetch_taken;
  logic        fetch_taken_slot;
  logic [31:0] next_pc;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_pc_gen #(
    .XLEN(32), .FETCH_WIDTH(2), .INST_BYTES(4),
    .RESET_VECTOR(32'h0000_1000), .RAS_DEPTH(8)
  ) dut (
    .CLK(CLK), .reset_n(reset_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pred_valid(pred_valid), .pred_is_branch(pred_is_branch),
    .pred_taken(pred_taken), .pred_is_call(pred_is_call),
    .pred_is_ret(pred_is_ret), .pred_target(pred_target),
    .ret_addr(ret_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_slot_mask(fetch_slot_mask), .fetch_taken(fetch_taken),
    .fetch_taken_slot(fetch_taken_slot), .next_pc(next_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  pv, br, tk;
    logic [31:0] t0, t1;
    logic [1:0]  mask;
    logic        taken;
    logic        slot;
    logic [31:0] nxt;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_preds();
    pred_valid = 2'b00; pred_is_branch = 2'b00; pred_taken = 2'b00;
    pred_is_call = 2'b00; pred_is_ret = 2'b00;
    pred_target = 64'd0; ret_addr = 64'd0;
  endtask

  task automatic check_idle(input string name);
    chk({name, ".valid"}, fetch_valid, 1'b0);
    chk({name, ".mask"}, fetch_slot_mask, 2'b00);
    chk({name, ".taken"}, fetch_taken, 1'b0);
    chk({name, ".slot"}, fetch_taken_slot, 1'b0);
  endtask

  task automatic check_group(input string name, input logic [31:0] pc, input logic [1:0] mask,
                             input logic tkn, input logic slot, input logic [31:0] nxt);
    chk({name, ".valid"}, fetch_valid, 1'b1);
    chk({name, ".pc"}, fetch_pc, pc);
    chk({name, ".mask"}, fetch_slot_mask, mask);
    chk({name, ".taken"}, fetch_taken, tkn);
    chk({name, ".slot"}, fetch_taken_slot, slot);
    chk({name, ".next"}, next_pc, nxt);
  endtask

  // Redirect to addr, sit through the bubble, end in RUN at addr.
  task automatic go_to(input logic [31:0] addr);
    redirect_valid = 1'b1; redirect_pc = addr;
    step();
    redirect_valid = 1'b0;
    step();
  endtask

  // Behavioural model of one fetch group.
  function automatic void ref_group(input logic [31:0] pc, input logic [1:0] pv, br, tk, rt,
                                    input logic [63:0] tg, ra, output logic [1:0] mask,
                                    output logic tkn, output logic slot, output logic [31:0] nxt);
    int first;
    logic [31:0] base;
    first = int'((pc % 32'd8) / 32'd4);
    base  = pc - (pc % 32'd8);
    nxt   = base + 32'd8;
    mask  = 2'b00; tkn = 1'b0; slot = 1'b0;
    for (int s = 0; s < 2; s++) begin
      if (s >= first && !tkn) begin
        mask[s] = 1'b1;
        if (pv[s] && (rt[s] || !br[s] || tk[s])) begin
          tkn  = 1'b1;
          slot = 1'(s);
          nxt  = rt[s] ? ra[s*32 +: 32] : tg[s*32 +: 32];
        end
      end
    end
  endfunction

  logic [31:0] m_pc;
  int          m_wait;
  logic [1:0]  e_mask;
  logic        e_tkn, e_slot, e_valid;
  logic [31:0] e_nxt;
  logic [31:0] ret_exp;

  initial begin
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; fetch_ready = 1'b1;
    clear_preds();

    // Reset held for three cycles, then release, boot cycle, sequential run.
    #1;
    check_idle("rst0");
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rst");
    end
    reset_n = 1'b1;
    #1;
    check_idle("boot");
    step();
    check_group("seq0", 32'h1000, 2'b11, 1'b0, 1'b0, 32'h1008);
    step();
    check_group("seq1", 32'h1008, 2'b11, 1'b0, 1'b0, 32'h1010);
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_group("stall", 32'h1008, 2'b11, 1'b0, 1'b0, 32'h1010);
    end
    fetch_ready = 1'b1;
    step();
    check_group("seq2", 32'h1010, 2'b11, 1'b0, 1'b0, 32'h1018);

    // Directed single-group table.
    vecs[0] = '{32'h2000, 2'b01, 2'b01, 2'b01, 32'h3004, 32'h0, 2'b01, 1'b1, 1'b0, 32'h3004};
    vecs[1] = '{32'h2000, 2'b11, 2'b11, 2'b11, 32'h4000, 32'h5000, 2'b01, 1'b1, 1'b0, 32'h4000};
    vecs[2] = '{32'h2000, 2'b11, 2'b01, 2'b00, 32'h0, 32'h4000, 2'b11, 1'b1, 1'b1, 32'h4000};
    vecs[3] = '{32'h2004, 2'b01, 2'b01, 2'b01, 32'h3000, 32'h0, 2'b10, 1'b0, 1'b0, 32'h2008};
    vecs[4] = '{32'hFFFF_FFF8, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b11, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{32'hFFFF_FFFC, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0};
    vecs[6] = '{32'h2004, 2'b10, 2'b10, 2'b00, 32'h0, 32'h8000, 2'b10, 1'b0, 1'b0, 32'h2008};
    vecs[7] = '{32'h2004, 2'b10, 2'b10, 2'b10, 32'h0, 32'hFFFF_FFF0, 2'b10, 1'b1, 1'b1, 32'hFFFF_FFF0};
    for (int v = 0; v < 8; v++) begin
      clear_preds();
      go_to(vecs[v].pc);
      pred_valid = vecs[v].pv; pred_is_branch = vecs[v].br; pred_taken = vecs[v].tk;
      pred_target = {vecs[v].t1, vecs[v].t0};
      #1;
      check_group($sformatf("vec%0d", v), vecs[v].pc, vecs[v].mask, vecs[v].taken,
                  vecs[v].slot, vecs[v].nxt);
      step();
      chk($sformatf("vec%0d.follow", v), fetch_pc, vecs[v].nxt);
    end

    // Taken branch into the second slot, then the following full group.
    clear_preds();
    go_to(32'h2000);
    pred_valid = 2'b01; pred_is_branch = 2'b01; pred_taken = 2'b01; pred_target = {32'h0, 32'h3004};
    #1;
    check_group("chain0", 32'h2000, 2'b01, 1'b1, 1'b0, 32'h3004);
    step();
    clear_preds();
    #1;
    check_group("chain1", 32'h3004, 2'b10, 1'b0, 1'b0, 32'h3008);
    step();
    check_group("chain2", 32'h3008, 2'b11, 1'b0, 1'b0, 32'h3010);

    // Redirect overriding a stall with a predicted-taken slot.
    go_to(32'h2000);
    pred_valid = 2'b01; pred_is_branch = 2'b01; pred_taken = 2'b01; pred_target = {32'h0, 32'h4000};
    fetch_ready = 1'b0;
    #1;
    check_group("rdst0", 32'h2000, 2'b01, 1'b1, 1'b0, 32'h4000);
    step();
    chk("rdst.held", fetch_pc, 32'h2000);
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    #1;
    check_idle("rdst.squash");
    step();
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    clear_preds();
    #1;
    check_idle("rdst.bubble");
    step();
    check_group("rdst.land", 32'h5000, 2'b11, 1'b0, 1'b0, 32'h5008);

    // Second redirect during the bubble wins and adds one more bubble cycle.
    redirect_valid = 1'b1; redirect_pc = 32'h5000;
    step();
    redirect_pc = 32'h6000;
    #1;
    check_idle("rdbub.first");
    step();
    redirect_valid = 1'b0;
    #1;
    check_idle("rdbub.extra");
    step();
    check_group("rdbub.land", 32'h6000, 2'b11, 1'b0, 1'b0, 32'h6008);

    // Misaligned redirect target is truncated to the instruction boundary.
    go_to(32'h2006);
    check_group("misalign", 32'h2004, 2'b10, 1'b0, 1'b0, 32'h2008);

    // Call in slot 1 then a return; target depends on the RAS build option.
    go_to(32'h6000);
    pred_valid = 2'b10; pred_is_call = 2'b10; pred_target = {32'h7000, 32'h0};
    #1;
    check_group("call", 32'h6000, 2'b11, 1'b1, 1'b1, 32'h7000);
    step();
    clear_preds();
    pred_valid = 2'b01; pred_is_ret = 2'b01;
    pred_target = {32'h0, 32'h0000_BAD0}; ret_addr = {32'h0, 32'h9000};
`ifdef FPC_RAS_EN
    ret_exp = 32'h6008;
`else
    ret_exp = 32'h9000;
`endif
    #1;
    check_group("ret", 32'h7000, 2'b01, 1'b1, 1'b0, ret_exp);
    step();
    chk("ret.follow", fetch_pc, ret_exp);

    // Reset asserted mid-operation.
    clear_preds();
    pred_valid = 2'b01;
    reset_n = 1'b0;
    #1;
    check_idle("midrst");
    step();
    reset_n = 1'b1;
    clear_preds();
    #1;
    check_idle("midrst.boot");
    step();
    check_group("midrst.run", 32'h1000, 2'b11, 1'b0, 1'b0, 32'h1008);

    // Randomized traffic against the behavioural model.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m_pc = 32'h1000; m_wait = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      fetch_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
      pred_valid     = 2'($urandom);
      pred_is_branch = 2'($urandom);
      pred_taken     = 2'($urandom);
      pred_is_call   = 2'($urandom);
`ifdef FPC_RAS_EN
      pred_is_ret    = 2'b00;
`else
      pred_is_ret    = 2'($urandom);
`endif
      pred_target    = {$urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC};
      ret_addr       = {$urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC};
      #1;
      e_valid = (m_wait == 0) && !redirect_valid;
      ref_group(m_pc, pred_valid, pred_is_branch, pred_taken, pred_is_ret,
                pred_target, ret_addr, e_mask, e_tkn, e_slot, e_nxt);
      chk("rnd.valid", fetch_valid, e_valid);
      if (e_valid) begin
        check_group("rnd", m_pc, e_mask, e_tkn, e_slot, e_nxt);
      end else begin
        chk("rnd.idle_mask", fetch_slot_mask, 2'b00);
      end
      if (redirect_valid) begin
        m_pc = redirect_pc & 32'hFFFF_FFFC; m_wait = 1;
      end else if (m_wait > 0) begin
        m_wait = m_wait - 1;
      end else if (fetch_ready) begin
        m_pc = e_nxt;
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
